// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared types and constants for the multi-engine mining core
package miner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MID,
        LOAD_HEAD,
        SOLVE,
        CLAIM,
        DONE
    } miner_state_t;

    localparam logic [1:0] SOL_NONE   = 2'b00;
    localparam logic [1:0] SOL_ACCEPT = 2'b01;
    localparam logic [1:0] SOL_REJECT = 2'b10;
    localparam logic [1:0] SOL_ABORT  = 2'b11;

    localparam int MID_BITS  = 256;
    localparam int HEAD_BITS = 512;

endpackage

// File: rtl/miner_array_core_if.sv
// rtl/miner_array_core_if.sv - host link: load stream in, solution claim/response out
interface miner_array_core_if #(
    parameter int DATA_W = 32
) ();

    logic              start_found;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        sol_response;
    logic              sol_claim;
    logic [31:0]       out_data;
    logic              busy;
    logic              exhausted;

    modport master (
        output start_found, in_valid, in_data, sol_response,
        input  sol_claim, out_data, busy, exhausted
    );

    modport slave (
        input  start_found, in_valid, in_data, sol_response,
        output sol_claim, out_data, busy, exhausted
    );

endinterface

// File: rtl/miner_array_core_word_stp_sr.sv
// rtl/miner_array_core_word_stp_sr.sv - word-wide shift register, first word ends at the MSBs
module word_stp_sr #(
    parameter int WIDTH      = 32,
    parameter int TOTAL_BITS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_enable,
    input  logic [WIDTH-1:0]      din,
    output logic [TOTAL_BITS-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            dout <= '0;
        end else if (shift_enable) begin
            dout <= {dout[TOTAL_BITS-WIDTH-1:0], din};
        end
    end

endmodule

// File: rtl/miner_array_core.sv
// rtl/miner_array_core.sv - loads a job, splits the nonce space across engines, arbitrates solutions
module miner_array_core
    import miner_pkg::*;
#(
    parameter int          NUM_CORES   = 4,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] NONCE_START = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    miner_array_core_if.slave      host,
    output logic [MID_BITS-1:0]    mid_data,
    output logic [HEAD_BITS-1:0]   head_data,
    output logic                   core_load,
    output logic [NUM_CORES-1:0]   core_en,
    output logic [32*NUM_CORES-1:0] core_nonce_base,
    output logic [NUM_CORES-1:0]   core_ack,
    input  logic [NUM_CORES-1:0]   core_found,
    input  logic [32*NUM_CORES-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]   core_done
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [6:0]       cnt_t;

    localparam cnt_t MID_LAST  = cnt_t'(MID_BITS / DATA_W - 1);
    localparam cnt_t HEAD_LAST = cnt_t'(HEAD_BITS / DATA_W - 1);
    localparam logic [63:0] STRIDE = 64'h1_0000_0000 / 64'(NUM_CORES);

    miner_state_t state, state_next;
    cnt_t         beat_cnt, cnt_next;
    logic [31:0]  out_q, out_next;
    idx_t         winner, winner_next;
    logic         load_next;
    logic         shift_mid, shift_head;

    logic                 found_any;
    idx_t                 found_idx;
    logic [31:0]          found_nonce;
    logic [NUM_CORES-1:0] ack_onehot;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_base
        localparam logic [63:0] BASE = 64'(NONCE_START) + 64'(i) * STRIDE;
        assign core_nonce_base[32*i +: 32] = BASE[31:0];
    end

    // Descending scan so the lowest-index finder is the one left standing.
    always_comb begin
        found_any   = |core_found;
        found_idx   = '0;
        found_nonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_found[i]) begin
                found_idx   = idx_t'(i);
                found_nonce = core_nonce[32*i +: 32];
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            ack_onehot[i] = (winner == idx_t'(i));
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = beat_cnt;
        out_next    = out_q;
        winner_next = winner;
        load_next   = 1'b0;
        shift_mid   = 1'b0;
        shift_head  = 1'b0;
        core_ack    = '0;
        if (host.start_found) begin
            state_next = LOAD_MID;
            cnt_next   = '0;
            out_next   = '0;
        end else begin
            case (state)
                LOAD_MID: begin
                    if (host.in_valid) begin
                        shift_mid = 1'b1;
                        if (beat_cnt == MID_LAST) begin
                            cnt_next   = '0;
                            state_next = LOAD_HEAD;
                        end else begin
                            cnt_next = beat_cnt + cnt_t'(1);
                        end
                    end
                end
                LOAD_HEAD: begin
                    if (host.in_valid) begin
                        shift_head = 1'b1;
                        if (beat_cnt == HEAD_LAST) begin
                            cnt_next   = '0;
                            load_next  = 1'b1;
                            state_next = SOLVE;
                        end else begin
                            cnt_next = beat_cnt + cnt_t'(1);
                        end
                    end
                end
                SOLVE: begin
                    if (found_any) begin
                        out_next    = found_nonce;
                        winner_next = found_idx;
                        state_next  = CLAIM;
                    end else if (&core_done) begin
                        state_next = DONE;
                    end
                end
                // Ack is issued in the response cycle so the engine has dropped
                // its found flag before the next SOLVE cycle arbitrates again.
                CLAIM: begin
                    case (host.sol_response)
                        SOL_REJECT: begin
                            core_ack   = ack_onehot;
                            state_next = SOLVE;
                        end
                        SOL_ACCEPT, SOL_ABORT: begin
                            core_ack   = ack_onehot;
                            state_next = IDLE;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            out_q     <= '0;
            winner    <= '0;
            core_load <= 1'b0;
        end else begin
            state     <= state_next;
            beat_cnt  <= cnt_next;
            out_q     <= out_next;
            winner    <= winner_next;
            core_load <= load_next;
        end
    end

    word_stp_sr #(.WIDTH(DATA_W), .TOTAL_BITS(MID_BITS)) u_mid_sr (
        .clk          (clk),
        .rst          (rst),
        .clear        (host.start_found),
        .shift_enable (shift_mid),
        .din          (host.in_data),
        .dout         (mid_data)
    );

    word_stp_sr #(.WIDTH(DATA_W), .TOTAL_BITS(HEAD_BITS)) u_head_sr (
        .clk          (clk),
        .rst          (rst),
        .clear        (host.start_found),
        .shift_enable (shift_head),
        .din          (host.in_data),
        .dout         (head_data)
    );

    assign core_en        = (state == SOLVE && !host.start_found) ? ~core_done : '0;
    assign host.sol_claim = (state == CLAIM);
    assign host.out_data  = out_q;
    assign host.busy      = (state != IDLE) && (state != DONE);
    assign host.exhausted = (state == DONE);

endmodule

// File: tb/tb_miner_array_core.sv
// tb/tb_miner_array_core.sv - scoreboard bench for the multi-engine mining core
module tb_miner_array_core;
    import miner_pkg::*;

    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    miner_array_core_if #(.DATA_W(32)) h ();
    miner_array_core_if #(.DATA_W(8))  h8 ();

    logic [255:0]      mid_data, mid8;
    logic [511:0]      head_data, head8;
    logic              core_load, load8;
    logic [NC-1:0]     core_en, core_ack, core_found, core_done, en8, ack8;
    logic [32*NC-1:0]  core_nonce_base, core_nonce, base8;
    logic [NC-1:0]     zero_flags = '0;
    logic [32*NC-1:0]  zero_nonce = '0;

    miner_array_core #(.NUM_CORES(NC), .DATA_W(32), .NONCE_START(32'h0)) dut (
        .clk(clk), .rst(rst), .host(h),
        .mid_data(mid_data), .head_data(head_data), .core_load(core_load),
        .core_en(core_en), .core_nonce_base(core_nonce_base), .core_ack(core_ack),
        .core_found(core_found), .core_nonce(core_nonce), .core_done(core_done)
    );

    miner_array_core #(.NUM_CORES(NC), .DATA_W(8), .NONCE_START(32'h0)) dut8 (
        .clk(clk), .rst(rst), .host(h8),
        .mid_data(mid8), .head_data(head8), .core_load(load8),
        .core_en(en8), .core_nonce_base(base8), .core_ack(ack8),
        .core_found(zero_flags), .core_nonce(zero_nonce), .core_done(zero_flags)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0]  exp_q[$];
    logic         claim_prev = 1'b0;
    logic [255:0] exp_mid, exp_mid8;
    logic [511:0] exp_head;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Every new claim must match the oldest expected nonce.
    always @(negedge clk) begin
        if (h.sol_claim && !claim_prev) begin
            if (exp_q.size() == 0) chk("claim_unexpected", h.sol_claim, 1'b0);
            else chk("claim_nonce", h.out_data, exp_q.pop_front());
        end
        claim_prev <= h.sol_claim;
    end

    task automatic load32(input bit do_start, input logic [31:0] first);
        exp_mid  = '0;
        exp_head = '0;
        if (do_start) begin
            tick();
            h.start_found = 1'b1;
        end
        for (int b = 0; b < 24; b++) begin
            tick();
            h.start_found = 1'b0;
            h.in_valid    = 1'b1;
            h.in_data     = first + 32'(b);
            if (b < 8) exp_mid = {exp_mid[223:0], first + 32'(b)};
            else exp_head = {exp_head[479:0], first + 32'(b)};
        end
        tick();
        h.in_valid = 1'b0;
        sample();
        chk("load_pulse", core_load, 1'b1);
        chk("load_core_en", core_en, 4'b1111);
        chk("load_mid", mid_data, exp_mid);
        chk("load_head", head_data, exp_head);
        tick();
        sample();
        chk("load_single_pulse", core_load, 1'b0);
    endtask

    initial begin
        h.start_found = 1'b0; h.in_valid = 1'b0; h.in_data = '0; h.sol_response = SOL_NONE;
        h8.start_found = 1'b0; h8.in_valid = 1'b0; h8.in_data = '0; h8.sol_response = SOL_NONE;
        core_found = '0; core_done = '0; core_nonce = '0;

        tick(); tick();
        sample();
        chk("rst_mid", mid_data, '0);
        chk("rst_head", head_data, '0);
        chk("rst_claim", h.sol_claim, 1'b0);
        chk("rst_out", h.out_data, '0);
        chk("rst_busy", h.busy, 1'b0);
        chk("rst_exh", h.exhausted, 1'b0);
        chk("rst_en", core_en, '0);
        chk("rst_ack", core_ack, '0);
        chk("rst_load", core_load, 1'b0);
        chk("rst8_misc", {h8.sol_claim, h8.busy, h8.exhausted, load8, en8, ack8, h8.out_data}, '0);
        chk("base0", core_nonce_base[31:0], 32'h0000_0000);
        chk("base1", core_nonce_base[63:32], 32'h4000_0000);
        chk("base2", core_nonce_base[95:64], 32'h8000_0000);
        chk("base3", core_nonce_base[127:96], 32'hC000_0000);
        chk("base8_3", base8[127:96], 32'hC000_0000);
        tick();
        rst = 1'b0;

        // Basic load with beats 1..24
        load32(1'b1, 32'd1);
        chk("mid_msb_word", mid_data[255:224], 32'd1);
        chk("head_lsb_word", head_data[31:0], 32'd24);

        // Simultaneous finds, reject then accept
        tick();
        core_nonce[63:32] = 32'h1234_5678;
        core_nonce[95:64] = 32'h9ABC_DEF0;
        core_found = 4'b0110;
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h9ABC_DEF0);
        sample();
        chk("claim_latency", h.sol_claim, 1'b0);
        tick(); sample();
        chk("claim1_up", h.sol_claim, 1'b1);
        chk("claim1_en", core_en, '0);
        chk("claim1_noack", core_ack, '0);
        tick(); sample();
        chk("claim1_hold", h.out_data, 32'h1234_5678);
        tick();
        h.sol_response = SOL_REJECT;
        sample();
        chk("reject_ack", core_ack, 4'b0010);
        tick();
        h.sol_response = SOL_NONE;
        core_found[1] = 1'b0;
        sample();
        chk("reject_claim_drop", h.sol_claim, 1'b0);
        chk("reject_busy", h.busy, 1'b1);
        chk("reject_ack_once", core_ack, '0);
        tick(); sample();
        chk("claim2_out", h.out_data, 32'h9ABC_DEF0);
        tick();
        h.sol_response = SOL_ACCEPT;
        sample();
        chk("accept_ack", core_ack, 4'b0100);
        tick();
        h.sol_response = SOL_NONE;
        core_found = '0;
        sample();
        chk("accept_idle_busy", h.busy, 1'b0);
        chk("accept_claim_drop", h.sol_claim, 1'b0);
        chk("accept_ack_once", core_ack, '0);

        // Staggered range exhaustion
        load32(1'b1, 32'h100);
        tick(); core_done = 4'b0001; sample(); chk("exh_en1", core_en, 4'b1110);
        tick(); core_done = 4'b0011; sample(); chk("exh_en2", core_en, 4'b1100);
        tick(); core_done = 4'b0111; sample(); chk("exh_en3", core_en, 4'b1000);
        tick(); core_done = 4'b1111; sample();
        chk("exh_en4", core_en, 4'b0000);
        chk("exh_not_yet", h.exhausted, 1'b0);
        tick(); sample();
        chk("exh_set", h.exhausted, 1'b1);
        chk("exh_busy", h.busy, 1'b0);
        tick(); core_done = '0; sample();
        chk("exh_sticky", h.exhausted, 1'b1);
        chk("exh_sticky_en", core_en, '0);

        // Abort after 8 mid and 5 head beats
        tick();
        h.start_found = 1'b1;
        for (int b = 0; b < 13; b++) begin
            tick();
            h.start_found = 1'b0;
            h.in_valid = 1'b1;
            h.in_data = 32'hA0 + 32'(b);
        end
        tick();
        h.in_valid = 1'b0;
        h.start_found = 1'b1;
        sample();
        chk("abort_partial_head", head_data[31:0], 32'hAC);
        tick();
        h.start_found = 1'b0;
        sample();
        chk("abort_mid_clear", mid_data, '0);
        chk("abort_head_clear", head_data, '0);
        chk("abort_exh_clear", h.exhausted, 1'b0);
        load32(1'b0, 32'h200);

        // Reset while claiming
        tick();
        core_nonce[31:0] = 32'hDEAD_BEEF;
        core_found = 4'b0001;
        exp_q.push_back(32'hDEAD_BEEF);
        tick(); sample();
        chk("rclaim_up", h.sol_claim, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        chk("rclaim_claim", h.sol_claim, 1'b0);
        chk("rclaim_out", h.out_data, '0);
        chk("rclaim_busy", h.busy, 1'b0);
        chk("rclaim_en", core_en, '0);
        chk("rclaim_ack", core_ack, '0);
        chk("rclaim_mid", mid_data, '0);
        chk("rclaim_head", head_data, '0);
        for (int c = 0; c < 5; c++) begin
            tick(); sample();
            chk("rclaim_needs_load", h.sol_claim, 1'b0);
        end
        core_found = '0;

        // Flow control on the 8-bit instance
        tick();
        h8.start_found = 1'b1;
        tick();
        h8.start_found = 1'b0;
        exp_mid8 = '0;
        for (int i = 0; i < 64; i++) begin
            h8.in_valid = (i % 2 == 0);
            h8.in_data = 8'(i / 2 + 1);
            if (i % 2 == 0) exp_mid8 = {exp_mid8[247:0], 8'(i / 2 + 1)};
            tick();
            if (i == 30 || i == 31) begin
                sample();
                chk(i == 30 ? "fc_mid_half" : "fc_idle_hold", mid8, exp_mid8);
            end
        end
        h8.in_valid = 1'b0;
        sample();
        chk("fc_mid_full", mid8, exp_mid8);
        chk("fc_head_empty", head8, '0);
        chk("fc_busy", h8.busy, 1'b1);
        h8.in_valid = 1'b1;
        h8.in_data = 8'hAA;
        tick();
        h8.in_valid = 1'b0;
        sample();
        chk("fc_mid_stays", mid8, exp_mid8);
        chk("fc_head_first", head8, 512'hAA);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/miner_array_core.md
Name: miner_array_core

Overview:
- Next-generation mining core. Loads midstate and header words from the host link, then dispatches them to NUM_CORES external SHA-256d hashing engines.
- The 32-bit nonce space is split evenly across the engines, and each engine sweeps its own sub-range.
- When engines report solutions, the block arbitrates between them and runs the sol_claim/sol_response handshake with the host.
- New relative to the single-engine core: multi-engine dispatch, a parametrised link width, in_valid flow control, reject-and-resume, and range-exhaustion reporting.

Parameters:
- NUM_CORES, 4, number of hashing engines; power of two, 1..16.
- DATA_W, 32, in_data width; one of 8, 16, 32, 64.
- NONCE_START, 32'h0000_0000, base nonce given to engine 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_found  in  1  one-cycle pulse that begins a new job.
- in_valid  in  1  in_data carries a valid beat this cycle.
- in_data  in  DATA_W  load word stream.
- sol_response  in  2  host reply: 00 none, 01 accept, 10 reject/continue, 11 abort.
- sol_claim  out  1  a solution is presented on out_data.
- out_data  out  32  winning nonce.
- busy  out  1  job in progress (any state other than IDLE or DONE).
- exhausted  out  1  all engines finished their ranges with no pending solution.
- mid_data  out  256  midstate; first beat loaded sits at the MSBs.
- head_data  out  512  header block; first beat loaded sits at the MSBs.
- core_load  out  1  one-cycle pulse telling engines to latch mid_data, head_data and base.
- core_en  out  NUM_CORES  per-engine run enable.
- core_nonce_base  out  32*NUM_CORES  start nonce for each engine; engine i occupies slice [32i+31:32i].
- core_ack  out  NUM_CORES  one-hot pulse that clears the found flag of the claimed engine.
- core_found  in  NUM_CORES  level signal; the engine holds it high until it sees core_ack.
- core_nonce  in  32*NUM_CORES  nonce found by each engine.
- core_done  in  NUM_CORES  level signal; the engine's range is exhausted.

Behaviour:
- Reset: state IDLE. All outputs 0, including mid_data and head_data. Beat counter 0.
- core_nonce_base is combinational and constant: NONCE_START + i*(2^32/NUM_CORES), computed mod 2^32.
- State machine states: IDLE, LOAD_MID, LOAD_HEAD, SOLVE, CLAIM, DONE.
- start_found in any state, including mid-load, SOLVE or CLAIM:
  - next state is LOAD_MID;
  - mid_data, head_data, the beat counter and out_data are cleared;
  - sol_claim, exhausted, core_en and core_ack are driven to 0.
- start_found has priority over every other event in the same cycle, including sol_response.
- LOAD_MID:
  - each cycle with in_valid=1, mid_data shifts left by DATA_W with in_data entering the LSBs, and the counter increments;
  - in_valid=0 holds all state;
  - after 256/DATA_W beats, the counter clears and the next state is LOAD_HEAD.
- LOAD_HEAD:
  - same shifting and counting rules, for 512/DATA_W beats into head_data;
  - on the cycle after the last beat, core_load=1 for exactly one cycle and the next state is SOLVE.
- SOLVE:
  - core_en is all ones, except engines with core_done=1, which get core_en=0.
  - If any core_found=1: the lowest-index finder k wins (fixed priority). Next cycle: out_data=core_nonce[k], sol_claim=1, core_en=0, state CLAIM. Latency from found to claim is 1 cycle.
  - Else, if every core_done=1: next state DONE.
  - found takes priority over done in the same cycle.
- CLAIM:
  - sol_claim and out_data are held stable and core_en stays 0 until sol_response is non-zero.
  - 01 (accept) or 11 (abort): next state IDLE; sol_claim=0; core_ack[k] pulses for one cycle.
  - 10 (reject): core_ack[k] pulses for one cycle; sol_claim=0; next state SOLVE; engines resume from their current nonce.
- Pending finds from other engines are not lost: their core_found stays high, so the next SOLVE cycle claims the next-lowest index.
- The engine index k used for core_ack is the registered winner captured at claim entry.
- DONE: exhausted=1 and core_en=0. Only start_found leaves this state; rst also exits it.
- sol_response is ignored outside CLAIM.
- in_valid and in_data are ignored outside LOAD_MID and LOAD_HEAD.

Decomposition:
- Package miner_pkg contains:
  - state enum miner_state_t;
  - response constants SOL_NONE, SOL_ACCEPT, SOL_REJECT, SOL_ABORT;
  - MID_BITS=256 and HEAD_BITS=512.
- One sub-module, word_stp_sr, parametrised by WIDTH and TOTAL_BITS, with clear and shift_enable. It is instantiated twice, once for mid_data and once for head_data.
- The priority encoder and nonce-base generation stay inline.

Test Plan:
- Load, DATA_W=32, NUM_CORES=4: start_found, then 24 beats with values 1..24 -> mid_data[255:224]=1, head_data[31:0]=24, a single core_load pulse, core_en=4'b1111, and core_nonce_base = 0, 0x4000_0000, 0x8000_0000, 0xC000_0000.
- Flow control, DATA_W=8: in_valid toggled every other cycle -> exactly 32 valid beats fill mid_data, and idle cycles do not shift.
- Simultaneous finds: core_found=4'b0110, core_nonce[1]=0x1234_5678, core_nonce[2]=0x9ABC_DEF0 -> claim 0x1234_5678 one cycle later; respond 10 -> core_ack=4'b0010, then the next claim is 0x9ABC_DEF0; respond 01 -> core_ack=4'b0100, state IDLE, busy=0.
- Exhaustion: core_done raised on engines 0..3 in staggered cycles with no finds -> each engine's core_en drops as it finishes, and exhausted=1 the cycle after the last core_done.
- Abort mid-load: start_found after 5 head beats -> mid_data=0, the counter restarts, and a full 24-beat reload succeeds.
- Reset during CLAIM: rst=1 -> all outputs 0 the next cycle; a later claim requires a fresh load.
